// File: rtl/am_rr_sel139_pkg.sv
// Shared definitions for the round-robin bus-select arbiter: FSM encodings,
// the idle select pattern and the active-low select decoder.
package am_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DEAD  = 2'd2
    } arb_state_e;

    localparam logic [3:0] Y_NONE = 4'b1111;

    // One-hot active-low decode of a 2-bit owner index.
    function automatic logic [3:0] sel_decode_n(input logic [1:0] s);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << s;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/am_rr_sel139_pick4.sv
// Combinational four-way round-robin picker: scans last+1, last+2, last+3
// and then last, and returns the first requester found.
module am_rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] win_o,
    output logic       any_o
);

    logic [1:0] cand;

    always_comb begin
        win_o = 2'd0;
        cand  = 2'd0;
        any_o = |req_i;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = 4; k >= 1; k--) begin
            cand = last_i + 2'(k);
            if (req_i[cand]) begin
                win_o = cand;
            end
        end
    end

endmodule

// File: rtl/am_rr_sel139.sv
// Four-way round-robin owner select with tenure limit, lock extension and a
// turnaround gap; drives a registered one-hot active-low select.
module am_rr_sel139
    import am_arb_pkg::*;
#(
    parameter int TENURE   = 16,
    parameter int DEAD_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [3:0] req,
    input  logic       lock,
    output logic [1:0] sel,
    output logic [3:0] y_,
    output logic       g_,
    output logic       busy,
    output arb_state_e dbg_state
);

    localparam int             CW        = $clog2(TENURE);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(TENURE - 1);
    localparam logic [1:0]     DEAD_LAST = (DEAD_CYC > 0) ? 2'(DEAD_CYC - 1) : 2'd0;

    arb_state_e    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dead_q, dead_d;
    logic [3:0]    y_q, y_d;
    logic          g_q, busy_q;

    logic [1:0]    pick_last;
    logic [1:0]    win;
    logic          any;
    logic          rel;

    // With no dead gap the releasing owner arbitrates in the same cycle, so
    // the rotation must start from the current owner rather than last_q.
    assign pick_last = (state_q == ST_GRANT) ? sel_q : last_q;

    am_rr_pick4 u_pick (
        .req_i  (req),
        .last_i (pick_last),
        .win_o  (win),
        .any_o  (any)
    );

    assign rel = !req[sel_q] || ((cnt_q == CNT_MAX) && !lock);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        dead_d  = dead_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    sel_d   = win;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (DEAD_CYC > 0) begin
                        state_d = ST_DEAD;
                        dead_d  = 2'd0;
                    end else if (any) begin
                        state_d = ST_GRANT;
                        sel_d   = win;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DEAD: begin
                if (dead_q == DEAD_LAST) begin
                    if (any) begin
                        state_d = ST_GRANT;
                        sel_d   = win;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dead_d = dead_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        y_d = (state_d == ST_GRANT) ? sel_decode_n(sel_d) : Y_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            cnt_q   <= '0;
            dead_q  <= 2'd0;
            y_q     <= Y_NONE;
            g_q     <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dead_q  <= dead_d;
            y_q     <= y_d;
            g_q     <= (state_d != ST_GRANT);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign sel       = sel_q;
    assign y_        = y_q;
    assign g_        = g_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_am_rr_sel139.sv
// Directed bench for am_rr_sel139: reset, rotation, early release, lock,
// lone-requester timeout (with and without dead gap) and mid-grant reset.
module tb_am_rr_sel139;
  import am_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_;
  logic [3:0] req;
  logic       lock;
  logic [1:0] sel;
  logic [3:0] y_;
  logic       g_;
  logic       busy;
  arb_state_e st;

  logic [3:0] req2;
  logic       lock2;
  logic [1:0] sel2;
  logic [3:0] y2_;
  logic       g2_;
  logic       busy2;
  arb_state_e st2;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  am_rr_sel139 #(.TENURE(16), .DEAD_CYC(1)) dut (
    .clk(clk), .rst_(rst_), .req(req), .lock(lock),
    .sel(sel), .y_(y_), .g_(g_), .busy(busy), .dbg_state(st)
  );

  am_rr_sel139 #(.TENURE(16), .DEAD_CYC(0)) dut_nd (
    .clk(clk), .rst_(rst_), .req(req2), .lock(lock2),
    .sel(sel2), .y_(y2_), .g_(g2_), .busy(busy2), .dbg_state(st2)
  );

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver helpers: advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count consecutive samples where y_ equals pat (bounded)
  task automatic hold_len(input logic [3:0] pat, output int n);
    n = 0;
    while (y_ === pat && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_y(input logic [3:0] pat, input int max_cyc, output logic ok);
    int c;
    c = 0;
    while (y_ !== pat && c < max_cyc) begin
      c++;
      tick();
    end
    ok = (y_ === pat);
  endtask

  initial begin
    int n;
    int good;
    logic ok;
    logic [3:0] nxt;

    rst_  = 1'b0;
    req   = 4'b1111;
    lock  = 1'b0;
    req2  = 4'b0100;
    lock2 = 1'b0;

    // reset with all requesting
    tick(); tick();
    chk("rst_y", y_, 4'b1111);
    chk("rst_g", g_, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sel, 2'b00);
    chk("rst_state", st, ST_IDLE);

    rst_ = 1'b1;
    tick();
    chk("first_y", y_, 4'b1110);
    chk("first_g", g_, 1'b0);
    chk("first_busy", busy, 1'b1);
    chk("first_state", st, ST_GRANT);

    // rotation 0 -> 1 -> 2 -> 3 -> 0, 16 cycles each, 1 dead cycle between
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b1110);
    nxt = 4'b1110;
    while (exp_q.size() > 0) begin
      hold_len(nxt, n);
      chk("rr_tenure", n, 16);
      chk("rr_dead_state", st, ST_DEAD);
      hold_len(4'b1111, n);
      chk("rr_dead_len", n, 1);
      nxt = exp_q.pop_front();
      chk("rr_next_owner", y_, nxt);
    end

    // early release: owner 0 drops, requester 2 takes over
    req = 4'b0100;
    tick();
    chk("drop0_y", y_, 4'b1111);
    tick();
    chk("grant2_y", y_, 4'b1011);
    chk("grant2_sel", sel, 2'd2);
    tick();
    chk("grant2_hold1", y_, 4'b1011);
    tick();
    chk("grant2_hold2", y_, 4'b1011);
    req = 4'b0001;
    tick();
    chk("early_rel_y", y_, 4'b1111);
    chk("early_rel_sel", sel, 2'd2);
    chk("early_rel_g", g_, 1'b1);
    tick();
    chk("after_dead_y", y_, 4'b1110);

    // lock: owner 1 keeps the bus for 40 cycles against full contention
    req = 4'b1110;
    tick();
    chk("drop0b_y", y_, 4'b1111);
    tick();
    chk("grant1_y", y_, 4'b1101);
    req  = 4'b1111;
    lock = 1'b1;
    good = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (y_ === 4'b1101) good++;
    end
    chk("lock_hold", good, 40);
    lock = 1'b0;
    tick();
    chk("unlock_rel_y", y_, 4'b1111);
    tick();
    chk("unlock_next_y", y_, 4'b1011);

    // lone requester 2 times out and is regranted
    req = 4'b0100;
    hold_len(4'b1011, n);
    chk("lone_tenure", n, 16);
    hold_len(4'b1111, n);
    chk("lone_dead", n, 1);
    chk("lone_regrant", y_, 4'b1011);

    // no dead gap: lone requester stays selected across tenure boundaries
    good = 0;
    for (int i = 0; i < 40; i++) begin
      if (y2_ === 4'b1011 && g2_ === 1'b0) good++;
      tick();
    end
    chk("nodead_cont", good, 40);
    chk("nodead_busy", busy2, 1'b1);

    // mid-grant reset while owner 3 holds the bus
    req = 4'b1000;
    wait_y(4'b0111, 60, ok);
    chk("reach_owner3", ok, 1'b1);
    rst_ = 1'b0;
    req  = 4'b1111;
    tick();
    chk("midrst_y", y_, 4'b1111);
    chk("midrst_sel", sel, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    rst_ = 1'b1;
    tick();
    chk("post_rst_y", y_, 4'b1110);
    chk("post_rst_sel", sel, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
